scon_modport: RTL and testbench
===============================

# scon_modport

Serial-port control register (8051-style SCON) for the UART subsystem. Each clock it captures mode, receive-enable and 9th-bit controls from the serial-port sequencer. It latches the transmit/receive completion events into sticky TI/RI flags. It presents the packed 8-bit SCON value to the register-read path.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state while low.
- mode  input  2  serial mode; mode[1]=SM0, mode[0]=SM1.
- ren  input  1  receive enable request.
- tb8_set  input  1  9th transmit bit value.
- rb8_receive  input  1  9th received bit value, valid with rx_complete.
- tx_complete  input  1  one-cycle pulse: transmission finished.
- rx_complete  input  1  one-cycle pulse: reception finished.
- scon  output  8  {SM0, SM1, SM2, REN, TB8, RB8, TI, RI}, registered.

## Operation
- scon[7:6] (SM0, SM1) <= mode every cycle.
- scon[5] (SM2) is constant 0; multiprocessor mode is not supported.
- scon[4] (REN) <= ren every cycle.
- scon[3] (TB8) <= tb8_set every cycle (level copy).
- scon[2] (RB8) <= rb8_receive only when rx_complete=1 and ren=1. Otherwise it holds (see Configuration for mode gating).
- scon[1] (TI): set when tx_complete=1. Sticky otherwise.
- scon[0] (RI): set when rx_complete=1 and ren=1. rx_complete with ren=0 is ignored and leaves both RI and RB8 unchanged.
- TI and RI clear only on reset or on a mode change, i.e. when the sampled mode differs from the current scon[7:6].
- Simultaneous mode change and completion pulse: the set wins, so the flag ends at 1 with the new mode.
- tx_complete and rx_complete in the same cycle: both flags set independently.
- Any input combination is legal; there are no illegal states.

## Timing
- Reset value: scon = 8'h00 immediately on reset falling (asynchronous). It is held while reset=0.
- On reset release, the first rising edge with reset=1 samples inputs normally.
- Latency: one cycle. Inputs sampled at edge N appear on scon after edge N.
- No handshake. Completion inputs are single-cycle pulses; a pulse held for several cycles re-sets the flag harmlessly.
- Reset asserted mid-operation discards all flags and captured RB8.

## Configuration
- Macro SCON_RB8_MODE_GATE_EN.
- Defined: RB8 capture is additionally qualified by 9-bit modes (mode = 2'b10 or 2'b11). In modes 0/1, RB8 holds its value while RI still sets.
- Undefined: RB8 captures on any rx_complete with ren=1, regardless of mode.

## Test plan
- Reset: drive reset=0 with all inputs at 1 -> scon=8'h00 asynchronously, with no clock edge needed.
- Field mapping: mode=2'b10, ren=1, tb8_set=1, no pulses -> scon=8'b1001_1000 one cycle later.
- TI sticky: mode=2'b01, pulse tx_complete once -> scon[1]=1 and stays 1 for 10 further cycles. Change mode to 2'b11 -> scon[1]=0.
- RI gating: ren=0 plus rx_complete pulse with rb8_receive=1 -> scon[2:0]=3'b000. Repeat with ren=1 in mode 2'b11 -> scon[2:0]=3'b101.
- Simultaneous: mode change 2'b00->2'b10 in the same cycle as a tx_complete pulse -> scon[7:6]=2'b10, scon[1]=1.
- Macro: mode=2'b01, ren=1, rx_complete with rb8_receive=1 -> scon[2]=0 with SCON_RB8_MODE_GATE_EN defined, 1 without; scon[0]=1 in both.

Source files
------------

// File: rtl/scon_modport.sv
// ---------------------------------------------------------------------------
// scon_modport
//
// Serial-port control register (8051-style SCON) for the UART subsystem.
// The mode, receive-enable and 9th-transmit-bit controls are copied from the
// serial-port sequencer on every clock. TX/RX completion pulses are latched
// into sticky TI/RI flags. The packed register goes to the register-read path.
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous active-low reset, clears all state
//   mode         in   2  serial mode, mode[1]=SM0, mode[0]=SM1
//   ren          in   1  receive enable request
//   tb8_set      in   1  9th transmit bit value
//   rb8_receive  in   1  9th received bit, valid with rx_complete
//   tx_complete  in   1  one-cycle pulse, transmission finished
//   rx_complete  in   1  one-cycle pulse, reception finished
//   scon         out  8  {SM0, SM1, SM2, REN, TB8, RB8, TI, RI}, registered
//
// Build option
//   SCON_RB8_MODE_GATE_EN : when defined, RB8 is captured only in the 9-bit
//                           modes (2'b10, 2'b11). RI still sets in every mode.
// ---------------------------------------------------------------------------
module scon_modport (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       ren,
    input  logic       tb8_set,
    input  logic       rb8_receive,
    input  logic       tx_complete,
    input  logic       rx_complete,
    output logic [7:0] scon
);

    logic [1:0] sm_q;
    logic       ren_q;
    logic       tb8_q;
    logic       rb8_q;
    logic       ti_q;
    logic       ri_q;

    logic       mode_change;
    logic       rx_accept;
    logic       rb8_capture;
    logic       ti_d;
    logic       ri_d;
    logic       rb8_d;

    // A new mode clears the completion flags. The comparison is against the
    // registered mode, so the clear takes effect only on a real change.
    always_comb begin
        mode_change = (mode != sm_q);
        rx_accept   = rx_complete & ren;
`ifdef SCON_RB8_MODE_GATE_EN
        // mode[1] (SM0) is high exactly in the two 9-bit modes.
        rb8_capture = rx_accept & mode[1];
`else
        rb8_capture = rx_accept;
`endif
    end

    // A completion pulse takes priority over the mode-change clear, so a
    // flag set in the same cycle as a mode switch ends up at 1.
    always_comb begin
        ti_d  = ti_q;
        ri_d  = ri_q;
        rb8_d = rb8_q;
        if (tx_complete) begin
            ti_d = 1'b1;
        end else if (mode_change) begin
            ti_d = 1'b0;
        end
        if (rx_accept) begin
            ri_d = 1'b1;
        end else if (mode_change) begin
            ri_d = 1'b0;
        end
        if (rb8_capture) begin
            rb8_d = rb8_receive;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sm_q  <= 2'b00;
            ren_q <= 1'b0;
            tb8_q <= 1'b0;
            rb8_q <= 1'b0;
            ti_q  <= 1'b0;
            ri_q  <= 1'b0;
        end else begin
            sm_q  <= mode;
            ren_q <= ren;
            tb8_q <= tb8_set;
            rb8_q <= rb8_d;
            ti_q  <= ti_d;
            ri_q  <= ri_d;
        end
    end

    // SM2 is tied low because multiprocessor address filtering is not
    // implemented.
    assign scon = {sm_q, 1'b0, ren_q, tb8_q, rb8_q, ti_q, ri_q};

endmodule

// File: tb/tb_scon_modport.sv
module tb_scon_modport;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       ren;
    logic       tb8_set;
    logic       rb8_receive;
    logic       tx_complete;
    logic       rx_complete;
    logic [7:0] scon;

    int checks   = 0;
    int failures = 0;

    // Reference state: the fields of SCON as the register-read path sees them.
    logic [1:0] m_mode;
    bit         m_ren, m_tb8, m_rb8, m_ti, m_ri;

    always #5 clk = ~clk;

    scon_modport dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .ren         (ren),
        .tb8_set     (tb8_set),
        .rb8_receive (rb8_receive),
        .tx_complete (tx_complete),
        .rx_complete (rx_complete),
        .scon        (scon)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_scon();
        return {m_mode, 1'b0, m_ren, m_tb8, m_rb8, m_ti, m_ri};
    endfunction

    task automatic model_reset();
        m_mode = 2'b00;
        m_ren  = 0;
        m_tb8  = 0;
        m_rb8  = 0;
        m_ti   = 0;
        m_ri   = 0;
    endtask

    // Apply one clock with the current inputs, advance the model and compare.
    task automatic tick(input string tag);
        bit   changed;
        bit   rx_ok;
        bit   rb8_ok;
        logic [1:0] s_mode;
        bit   s_ren, s_tb8, s_rb8, s_tx, s_rx;
        s_mode = mode;
        s_ren  = ren;
        s_tb8  = tb8_set;
        s_rb8  = rb8_receive;
        s_tx   = tx_complete;
        s_rx   = rx_complete;
        changed = (s_mode != m_mode);
        rx_ok   = s_rx && s_ren;
`ifdef SCON_RB8_MODE_GATE_EN
        rb8_ok  = rx_ok && (s_mode == 2'b10 || s_mode == 2'b11);
`else
        rb8_ok  = rx_ok;
`endif
        @(posedge clk);
        #1;
        m_ti   = s_tx  ? 1'b1 : (changed ? 1'b0 : m_ti);
        m_ri   = rx_ok ? 1'b1 : (changed ? 1'b0 : m_ri);
        if (rb8_ok) m_rb8 = s_rb8;
        m_mode = s_mode;
        m_ren  = s_ren;
        m_tb8  = s_tb8;
        check_eq(tag, scon, model_scon());
    endtask

    initial begin
        logic [7:0] v;
        reset       = 1'b0;
        mode        = 2'b11;
        ren         = 1'b1;
        tb8_set     = 1'b1;
        rb8_receive = 1'b1;
        tx_complete = 1'b1;
        rx_complete = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", scon, 8'h00);

        @(negedge clk);
        reset       = 1'b1;
        mode        = 2'b00;
        ren         = 1'b0;
        tb8_set     = 1'b0;
        rb8_receive = 1'b0;
        tx_complete = 1'b0;
        rx_complete = 1'b0;

        // field mapping
        mode = 2'b10; ren = 1'b1; tb8_set = 1'b1;
        tick("field_map_model");
        check_eq("field_map", scon, 8'b1001_1000);

        // TI sticky, then cleared by a mode change
        mode = 2'b01; tx_complete = 1'b1;
        tick("ti_set_model");
        tx_complete = 1'b0;
        for (int i = 0; i < 10; i++) tick("ti_sticky_model");
        v = {7'b0, scon[1]};
        check_eq("ti_sticky", v, 8'h01);
        mode = 2'b11;
        tick("ti_clear_model");
        v = {7'b0, scon[1]};
        check_eq("ti_mode_clear", v, 8'h00);

        // RI gating by ren
        ren = 1'b0; rx_complete = 1'b1; rb8_receive = 1'b1;
        tick("ri_ren0_model");
        v = {5'b0, scon[2:0]};
        check_eq("ri_ren0", v, 8'b000);
        ren = 1'b1;
        tick("ri_ren1_model");
        v = {5'b0, scon[2:0]};
        check_eq("ri_ren1", v, 8'b101);
        rx_complete = 1'b0;

        // mode change simultaneous with tx_complete: set wins
        mode = 2'b00;
        tick("simul_pre_model");
        mode = 2'b10; tx_complete = 1'b1;
        tick("simul_model");
        v = {6'b0, scon[7:6]};
        check_eq("simul_mode", v, 8'h02);
        v = {7'b0, scon[1]};
        check_eq("simul_ti", v, 8'h01);
        tx_complete = 1'b0;

        // RB8 mode gating; first load RB8=0 in a 9-bit mode
        mode = 2'b11; ren = 1'b1; rx_complete = 1'b1; rb8_receive = 1'b0;
        tick("rb8_zero_model");
        rx_complete = 1'b0;
        mode = 2'b01;
        tick("gate_pre_model");
        rx_complete = 1'b1; rb8_receive = 1'b1;
        tick("gate_model");
        rx_complete = 1'b0;
        v = {7'b0, scon[2]};
`ifdef SCON_RB8_MODE_GATE_EN
        check_eq("gate_rb8", v, 8'h00);
`else
        check_eq("gate_rb8", v, 8'h01);
`endif
        v = {7'b0, scon[0]};
        check_eq("gate_ri", v, 8'h01);

        // randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            ren         = ($urandom_range(0, 3) != 0);
            tb8_set     = 1'($urandom);
            rb8_receive = 1'($urandom);
            tx_complete = ($urandom_range(0, 5) == 0);
            rx_complete = ($urandom_range(0, 5) == 0);
            tick("rand");
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                model_reset();
                check_eq("async_reset", scon, 8'h00);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        // a final mid-cycle reset with all inputs high
        mode = 2'b11; ren = 1'b1; tb8_set = 1'b1; tx_complete = 1'b1;
        rx_complete = 1'b1; rb8_receive = 1'b1;
        tick("final_load");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("final_async_reset", scon, 8'h00);
        @(posedge clk);
        #1;
        check_eq("final_reset_hold", scon, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
